shift_unit: RTL and testbench

Multi-cycle parametrised shifter for the datapath, generalising the fixed shift-left-by-2 used for branch offsets into a variable-amount unit with logical-left, logical-right and arithmetic-right modes. The unit shifts up to STEP bit positions per cycle, so latency scales with the shift amount. A start/busy/done handshake lets the execute-stage control stall while the shift is in progress.

---
 rtl/shift_unit.sv | 98 +++++++++
 tb/tb_shift_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/shift_unit.sv
// Multi-cycle variable shifter (SLL/SRL/SRA, optional ROR) moving at most STEP bits per cycle.
// Define SHIFT_UNIT_ROTATE_EN to make op=11 a rotate-right; otherwise op=11 behaves as SLL.
module shift_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // rem never exceeds WIDTH-1, so capping STEP there leaves min(rem, STEP) unchanged.
    localparam logic [SHW-1:0] STEP_CAP = (STEP >= WIDTH) ? {SHW{1'b1}} : SHW'(STEP);

    state_t           state, state_next;
    logic             accept;
    logic [WIDTH-1:0] acc, acc_step, hi_mask;
    logic [SHW-1:0]   rem, rem_step, amt;
    logic [1:0]       op_q;
    logic             sign;

    // One shift step of the in-flight operand.
    always_comb begin
        amt      = (rem < STEP_CAP) ? rem : STEP_CAP;
        rem_step = rem - amt;
        hi_mask  = ~({WIDTH{1'b1}} >> amt);
        case (op_q)
            2'b01:   acc_step = acc >> amt;
            2'b10:   acc_step = (acc >> amt) | (sign ? hi_mask : '0);
`ifdef SHIFT_UNIT_ROTATE_EN
            2'b11:   acc_step = (acc >> amt) | (acc << ((SHW+1)'(WIDTH) - {1'b0, amt}));
`endif
            default: acc_step = acc << amt;
        endcase
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = (shamt != '0) ? SHIFT : DONE;
                end else if (state == DONE) begin
                    state_next = IDLE;
                end
            end
            SHIFT: begin
                if (rem_step == '0) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            rem  <= '0;
            y    <= '0;
            op_q <= '0;
            sign <= 1'b0;
        end else if (accept) begin
            acc  <= a;
            rem  <= shamt;
            op_q <= op;
            sign <= a[WIDTH-1];
            if (shamt == '0) y <= a;
        end else if (state == SHIFT) begin
            acc <= acc_step;
            rem <= rem_step;
            if (rem_step == '0) y <= acc_step;
        end
    end

    // Both flags decode the state register directly, so they carry no input path.
    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_shift_unit.sv
// Self-checking bench for shift_unit: directed cases plus random ops against an arithmetic model.
module tb_shift_unit;

    localparam int WIDTH = 32;
    localparam int STEP  = 4;
    localparam int SHW   = $clog2(WIDTH);

    logic             clk;
    logic             rst;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [SHW-1:0]   shamt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] y;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] exp_q[$];
    int               lat_q[$];
    logic [WIDTH-1:0] last_y;

    shift_unit #(.WIDTH(WIDTH), .STEP(STEP)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .shamt (shamt),
        .busy  (busy),
        .done  (done),
        .y     (y)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain shift semantics from the operation table.
    function automatic logic [WIDTH-1:0] model(input logic [1:0] o, input logic [WIDTH-1:0] x, input int s);
        logic [WIDTH-1:0] r;
        case (o)
            2'b01: r = x >> s;
            2'b10: r = WIDTH'($signed(x) >>> s);
`ifdef SHIFT_UNIT_ROTATE_EN
            2'b11: r = (s == 0) ? x : ((x >> s) | (x << (WIDTH - s)));
`endif
            default: r = x << s;
        endcase
        return r;
    endfunction

    // Driver: present a request in the current cycle; accepted at the next posedge.
    task automatic issue(input logic [1:0] o, input logic [WIDTH-1:0] x, input int s);
        start = 1'b1;
        op    = o;
        a     = x;
        shamt = SHW'(s);
        exp_q.push_back(model(o, x, s));
        lat_q.push_back((s + STEP - 1) / STEP);
    endtask

    // Follow one operation from its accept edge to its DONE cycle. Leaves us at the DONE negedge.
    task automatic track(input bit poke);
        logic [WIDTH-1:0] ey;
        int               n;
        ey = exp_q.pop_front();
        n  = lat_q.pop_front();
        for (int k = 1; k <= n + 1; k++) begin
            @(negedge clk);
            if (k == n + 1) begin
                check("done_pulse", done, 1);
                check("busy_in_done", busy, 0);
                check("result", y, ey);
            end else begin
                check("busy_in_shift", busy, 1);
                check("done_in_shift", done, 0);
            end
            // Inputs are free to change after acceptance; pokes during SHIFT must be ignored.
            start = (poke && k <= n) ? 1'b1 : 1'b0;
            a     = $urandom;
            op    = 2'($urandom_range(0, 3));
            shamt = SHW'($urandom_range(0, WIDTH - 1));
        end
        last_y = ey;
    endtask

    task automatic idle_check();
        @(negedge clk);
        check("idle_done", done, 0);
        check("idle_busy", busy, 0);
        check("y_hold", y, last_y);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        shamt = '0;
        last_y = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_y", y, 0);
        rst = 1'b0;

        // Directed cases
        @(negedge clk); issue(2'b00, 32'h0000_0001, 2);  track(0); idle_check();
        @(negedge clk); issue(2'b10, 32'h8000_0000, 31); track(0); idle_check();
        check("sra_value", last_y, 32'hFFFF_FFFF);
        @(negedge clk); issue(2'b01, 32'h8000_0000, 31); track(0); idle_check();
        check("srl_value", last_y, 32'h0000_0001);
        @(negedge clk); issue(2'b00, 32'hDEAD_BEEF, 0);  track(0); idle_check();
        @(negedge clk); issue(2'b11, 32'h8000_0001, 4);  track(0); idle_check();
`ifdef SHIFT_UNIT_ROTATE_EN
        check("op11_value", last_y, 32'h1800_0000);
`else
        check("op11_value", last_y, 32'h0000_0010);
`endif

        // Start during SHIFT is ignored; back-to-back accept on the DONE edge.
        @(negedge clk); issue(2'b00, 32'h0000_0003, 9); track(1);
        issue(2'b01, 32'hF000_0000, 5); track(0);
        issue(2'b00, 32'h1234_5678, 0); track(0); idle_check();

        // Reset during the third SHIFT cycle discards the operation.
        @(negedge clk); issue(2'b00, 32'h0000_FFFF, 31);
        void'(exp_q.pop_front());
        void'(lat_q.pop_front());
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_y", y, 0);
        rst = 1'b0;
        issue(2'b10, 32'h8765_4321, 13); track(0); idle_check();

        // Random operations, mixing idle gaps, back-to-back starts and ignored pokes.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 0) idle_check();
            issue(2'($urandom_range(0, 3)), $urandom, $urandom_range(0, WIDTH - 1));
            track(bit'($urandom_range(0, 1)));
        end
        idle_check();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: got no completion expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
